global_tone_map_v2: RTL and testbench
=====================================

// Module: global_tone_map_v2
// PURPOSE
//  Two-pass global tone mapper for the DE2-115 image path, operating in place on a single-port frame RAM.
//  Pass 1 reads each pixel, normalises it against the radiance window, maps it through a run-time-loadable
//  tone LUT, writes it back and tracks the mapped min/max. Optional pass 2 contrast-stretches to full scale.
//  Successor to the fixed-table tone block: parametrised widths, loadable LUT, bypassable stretch, div-by-0 safe.
// PARAMETERS
//  D_W       16  input pixel / radiance width
//  OUT_W      8  mapped pixel width (LUT data width); written data zero-extended to D_W
//  LUT_AW     8  LUT index width; depth 2**LUT_AW
//  ADDR_W    18  frame RAM address width
//  NUM_W     18  pixel-count width
//  BASE_ADDR  0  address of pixel 0
// PORTS
//  i_clk         in   1       clock
//  rst_n         in   1       async active-low reset
//  i_start       in   1       start pulse; sampled only in IDLE
//  i_abort       in   1       return to IDLE without done
//  i_stretch_en  in   1       1: run pass 2; sampled with i_start
//  i_total       in   NUM_W   pixel count; sampled with i_start
//  i_rad_min     in   D_W     radiance window low end
//  i_rad_range   in   D_W     radiance window span (max-min)
//  i_lut_we      in   1       LUT write strobe (IDLE only)
//  i_lut_addr    in   LUT_AW  LUT write index
//  i_lut_wdata   in   OUT_W   LUT write data
//  o_addr        out  ADDR_W  RAM address
//  o_wen         out  1       RAM write enable
//  o_wdata       out  D_W     RAM write data
//  i_rdata       in   D_W     RAM read data, valid 1 cycle after o_addr presented with o_wen=0
//  o_busy        out  1       high from cycle after accepted start until return to IDLE
//  o_done        out  1       one-cycle pulse on completion
//  o_min, o_max  out  OUT_W   pass-1 mapped min/max (stable after done)
// BEHAVIOUR
//  Reset: state IDLE; o_addr=0, o_wen=0, o_wdata=0, o_busy=0, o_done=0, o_min=all-ones, o_max=0;
//   LUT entry k = (k*(2**OUT_W-1))/(2**LUT_AW-1) (identity ramp). Reset mid-run aborts immediately.
//  States: IDLE,P1_ADDR,P1_READ,P1_MAP,P1_WR,P2_ADDR,P2_READ,P2_NORM,P2_WR,DONE. 4 cycles/pixel/pass.
//  IDLE: i_start -> latch total/stretch_en, idx=0, min=all-ones, max=0; total==0 -> DONE, else P1_ADDR.
//  Px_ADDR: o_addr=BASE_ADDR+idx, o_wen=0. Px_READ: capture i_rdata into pix.
//  P1_MAP: x = (pix<i_rad_min)?0:pix-i_rad_min; range==0 -> q=0, else q=(x<<LUT_AW)/range,
//   saturate to 2**LUT_AW-1; v=LUT[q] registered. Division is full-width, no truncation before saturation.
//  P1_WR: o_wen=1, o_wdata={0,v}, same address; min=min(min,v), max=max(max,v);
//   idx<total-1 -> idx++, P1_ADDR; else stretch_en ? (idx=0, P2_ADDR) : DONE.
//  P2_NORM: max==min -> v2=v unchanged; else v2=((v-min)*(2**OUT_W-1))/(max-min) (v read back, low OUT_W).
//  P2_WR: o_wen=1, o_wdata={0,v2}; last pixel -> DONE else idx++, P2_ADDR.
//  DONE: o_done=1 for exactly one cycle, o_wen=0, -> IDLE. o_busy low in IDLE and DONE cycle.
//  i_abort (any non-IDLE state): next cycle IDLE, o_wen=0, no o_done; abort beats last-write transition.
//  i_start while busy ignored. LUT writes when not IDLE ignored; LUT write and start same cycle: both take
//   effect, write lands before first P1_MAP.
//  o_wen is high only in Px_WR cycles; every write targets the address read 3 cycles earlier.
// TESTING
//  Reset, 4 px [0,64,128,255], min=0,range=256, identity LUT, stretch=0 -> RAM [0,64,128,255], done at cycle 17.
//  Load LUT[k]=255-k, same image -> RAM [255,191,127,0]; o_min=0,o_max=255.
//  Pixels [100,150], min=100,range=100, stretch=1 -> pass1 [0,128], pass2 [0,255]; 16 cycles busy.
//  range=0 and all-equal pixels with stretch=1 -> all outputs 0, no X, done pulses once.
//  Pixel below min / above min+range -> written 0 / LUT[255] (saturation).
//  Abort mid pass 2; total=0; start while busy; LUT write while busy -> no done / immediate done / ignored / LUT unchanged.

Source files
------------

// File: rtl/global_tone_map_v2.sv
// rtl/global_tone_map_v2.sv - two-pass in-place global tone mapper with loadable LUT and optional contrast stretch
module global_tone_map_v2 #(
    parameter int                D_W       = 16,
    parameter int                OUT_W     = 8,
    parameter int                LUT_AW    = 8,
    parameter int                ADDR_W    = 18,
    parameter int                NUM_W     = 18,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              i_clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_stretch_en,
    input  logic [NUM_W-1:0]  i_total,
    input  logic [D_W-1:0]    i_rad_min,
    input  logic [D_W-1:0]    i_rad_range,
    input  logic              i_lut_we,
    input  logic [LUT_AW-1:0] i_lut_addr,
    input  logic [OUT_W-1:0]  i_lut_wdata,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_wen,
    output logic [D_W-1:0]    o_wdata,
    input  logic [D_W-1:0]    i_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [OUT_W-1:0]  o_min,
    output logic [OUT_W-1:0]  o_max
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_P1_ADDR,
        S_P1_READ,
        S_P1_MAP,
        S_P1_WR,
        S_P2_ADDR,
        S_P2_READ,
        S_P2_NORM,
        S_P2_WR,
        S_DONE
    } state_t;

    localparam int               LUT_N   = 1 << LUT_AW;
    localparam int               Q_W     = D_W + LUT_AW;
    localparam int               P_W     = 2 * OUT_W;
    localparam logic [Q_W-1:0]   Q_MAX   = Q_W'(LUT_N - 1);
    localparam logic [OUT_W-1:0] OUT_MAX = '1;

    state_t             state_q, state_d;
    logic [NUM_W-1:0]   total_q, total_d;
    logic [NUM_W-1:0]   idx_q, idx_d;
    logic               stretch_q, stretch_d;
    logic [D_W-1:0]     pix_q, pix_d;
    logic [OUT_W-1:0]   v_q, v_d;
    logic [OUT_W-1:0]   min_q, min_d;
    logic [OUT_W-1:0]   max_q, max_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wen_q, wen_d;
    logic [D_W-1:0]     wdata_q, wdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [OUT_W-1:0]   lut_q [LUT_N];

    // Pass-1 datapath: window normalise, full-width divide, saturate, LUT lookup
    logic [D_W-1:0]     norm_x;
    logic [Q_W-1:0]     q_full;
    logic [LUT_AW-1:0]  q_idx;
    logic [OUT_W-1:0]   lut_v;

    always_comb begin
        norm_x = (pix_q < i_rad_min) ? '0 : pix_q - i_rad_min;
        q_full = '0;
        if (i_rad_range != '0) begin
            q_full = (Q_W'(norm_x) << LUT_AW) / Q_W'(i_rad_range);
        end
        q_idx = (q_full > Q_MAX) ? '1 : q_full[LUT_AW-1:0];
        lut_v = lut_q[q_idx];
    end

    // Pass-2 datapath: stretch [min,max] to full scale; degenerate span leaves pixel as is
    logic [OUT_W-1:0]   v_rb;
    logic [OUT_W-1:0]   span;
    logic [OUT_W-1:0]   diff;
    logic [P_W-1:0]     prod;
    logic [P_W-1:0]     quot;
    logic [OUT_W-1:0]   v2;

    always_comb begin
        v_rb = pix_q[OUT_W-1:0];
        span = max_q - min_q;
        diff = (v_rb > min_q) ? v_rb - min_q : '0;
        prod = P_W'(diff) * P_W'(OUT_MAX);
        quot = '0;
        v2   = v_rb;
        if (max_q > min_q) begin
            quot = prod / P_W'(span);
            v2   = (quot > P_W'(OUT_MAX)) ? OUT_MAX : quot[OUT_W-1:0];
        end
    end

    logic last_px;
    assign last_px = (idx_q == total_q - NUM_W'(1));

    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        idx_d     = idx_q;
        stretch_d = stretch_q;
        pix_d     = pix_q;
        v_d       = v_q;
        min_d     = min_q;
        max_d     = max_q;
        addr_d    = addr_q;
        wen_d     = 1'b0;
        wdata_d   = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    total_d   = i_total;
                    stretch_d = i_stretch_en;
                    idx_d     = '0;
                    min_d     = '1;
                    max_d     = '0;
                    if (i_total == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_P1_ADDR;
                        addr_d  = BASE_ADDR;
                    end
                end
            end
            S_P1_ADDR: state_d = S_P1_READ;
            S_P1_READ: begin
                pix_d   = i_rdata;
                state_d = S_P1_MAP;
            end
            S_P1_MAP: begin
                v_d     = lut_v;
                wdata_d = D_W'(lut_v);
                wen_d   = 1'b1;
                state_d = S_P1_WR;
            end
            S_P1_WR: begin
                if (v_q < min_q) min_d = v_q;
                if (v_q > max_q) max_d = v_q;
                if (!last_px) begin
                    idx_d   = idx_q + NUM_W'(1);
                    addr_d  = BASE_ADDR + ADDR_W'(idx_d);
                    state_d = S_P1_ADDR;
                end else if (stretch_q) begin
                    idx_d   = '0;
                    addr_d  = BASE_ADDR;
                    state_d = S_P2_ADDR;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_P2_ADDR: state_d = S_P2_READ;
            S_P2_READ: begin
                pix_d   = i_rdata;
                state_d = S_P2_NORM;
            end
            S_P2_NORM: begin
                wdata_d = D_W'(v2);
                wen_d   = 1'b1;
                state_d = S_P2_WR;
            end
            S_P2_WR: begin
                if (last_px) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + NUM_W'(1);
                    addr_d  = BASE_ADDR + ADDR_W'(idx_d);
                    state_d = S_P2_ADDR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition, including the one out of the final write
        if (state_q != S_IDLE && i_abort) begin
            state_d = S_IDLE;
            wen_d   = 1'b0;
        end

        done_d = (state_d == S_DONE);
        busy_d = !(state_d inside {S_IDLE, S_DONE});
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            total_q   <= '0;
            idx_q     <= '0;
            stretch_q <= 1'b0;
            pix_q     <= '0;
            v_q       <= '0;
            min_q     <= '1;
            max_q     <= '0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            idx_q     <= idx_d;
            stretch_q <= stretch_d;
            pix_q     <= pix_d;
            v_q       <= v_d;
            min_q     <= min_d;
            max_q     <= max_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Table comes up as an identity ramp; writes accepted only while idle
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LUT_N; k++) begin
                lut_q[k] <= OUT_W'((k * ((1 << OUT_W) - 1)) / (LUT_N - 1));
            end
        end else if (i_lut_we && state_q == S_IDLE) begin
            lut_q[i_lut_addr] <= i_lut_wdata;
        end
    end

    assign o_addr  = addr_q;
    assign o_wen   = wen_q;
    assign o_wdata = wdata_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_min   = min_q;
    assign o_max   = max_q;

endmodule

// File: tb/tb_global_tone_map_v2.sv
// tb/tb_global_tone_map_v2.sv - scoreboard bench for global_tone_map_v2 with a synchronous frame RAM model
module tb_global_tone_map_v2;

    logic        i_clk = 1'b0;
    logic        rst_n;
    logic        i_start, i_abort, i_stretch_en;
    logic [17:0] i_total;
    logic [15:0] i_rad_min, i_rad_range;
    logic        i_lut_we;
    logic [7:0]  i_lut_addr, i_lut_wdata;
    logic [17:0] o_addr;
    logic        o_wen;
    logic [15:0] o_wdata;
    logic [15:0] i_rdata;
    logic        o_busy, o_done;
    logic [7:0]  o_min, o_max;

    global_tone_map_v2 dut (
        .i_clk(i_clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_stretch_en(i_stretch_en), .i_total(i_total), .i_rad_min(i_rad_min),
        .i_rad_range(i_rad_range), .i_lut_we(i_lut_we), .i_lut_addr(i_lut_addr),
        .i_lut_wdata(i_lut_wdata), .o_addr(o_addr), .o_wen(o_wen), .o_wdata(o_wdata),
        .i_rdata(i_rdata), .o_busy(o_busy), .o_done(o_done), .o_min(o_min), .o_max(o_max)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Frame RAM: one-cycle read latency, preload port for the bench
    logic [15:0] mem [16];
    logic        pl_we = 1'b0;
    logic [3:0]  pl_addr;
    logic [15:0] pl_data;
    always @(posedge i_clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (o_wen) mem[o_addr[3:0]] <= o_wdata;
        i_rdata <= mem[o_addr[3:0]];
    end

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;
    typedef struct packed {
        int         lat;
        logic [7:0] mn;
        logic [7:0] mx;
        int         busy;
    } done_t;
    typedef struct packed {
        logic        full;
        logic        busy;
        logic        done;
        logic        wen;
        logic [17:0] addr;
        logic [15:0] wdata;
        logic [7:0]  mn;
        logic [7:0]  mx;
    } probe_t;

    wr_t    wq[$];
    done_t  dq[$];
    probe_t pq[$];

    int n_cmp = 0;
    int n_err = 0;
    int start_cyc = 0;
    int deadline = 1000000;
    int busy_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: the only process that compares
    always @(negedge i_clk) begin
        if (rst_n) begin
            if (o_wen) begin
                if (wq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_write: addr %0d data %0d, none expected", o_addr, o_wdata);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("wr_addr", 64'(o_addr), 64'(w.addr));
                    check("wr_data", 64'(o_wdata), 64'(w.data));
                end
            end
            if (o_done) begin
                if (dq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_done: got pulse, expected none");
                end else begin
                    done_t d;
                    d = dq.pop_front();
                    check("done_latency", 64'(cyc - start_cyc + 1), 64'(d.lat));
                    check("done_min", 64'(o_min), 64'(d.mn));
                    check("done_max", 64'(o_max), 64'(d.mx));
                    check("busy_cycles", 64'(busy_run), 64'(d.busy));
                end
                busy_run = 0;
            end else if (o_busy) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
            if (pq.size() != 0) begin
                probe_t p;
                p = pq.pop_front();
                check("probe_busy", 64'(o_busy), 64'(p.busy));
                check("probe_done", 64'(o_done), 64'(p.done));
                check("probe_wen", 64'(o_wen), 64'(p.wen));
                check("probe_min", 64'(o_min), 64'(p.mn));
                check("probe_max", 64'(o_max), 64'(p.mx));
                if (p.full) begin
                    check("probe_addr", 64'(o_addr), 64'(p.addr));
                    check("probe_wdata", 64'(o_wdata), 64'(p.wdata));
                end
            end
            if ((wq.size() != 0 || dq.size() != 0) && cyc > deadline) begin
                n_cmp++; n_err++;
                $display("FAIL timeout: got %0d writes and %0d done still pending, expected 0", wq.size(), dq.size());
                wq.delete();
                dq.delete();
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_px(input logic [3:0] a, input logic [15:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic lut_write(input logic [7:0] a, input logic [7:0] d);
        i_lut_we = 1'b1; i_lut_addr = a; i_lut_wdata = d;
        tick();
        i_lut_we = 1'b0;
    endtask

    task automatic push_wr(input logic [17:0] a, input logic [15:0] d);
        wq.push_back('{addr: a, data: d});
    endtask

    task automatic push_done(input int lat, input logic [7:0] mn, input logic [7:0] mx, input int busy);
        dq.push_back('{lat: lat, mn: mn, mx: mx, busy: busy});
    endtask

    task automatic start_run(input logic [17:0] total, input logic stretch,
                             input logic [15:0] rmin, input logic [15:0] rrange, input int limit);
        i_total = total; i_stretch_en = stretch; i_rad_min = rmin; i_rad_range = rrange;
        i_start = 1'b1;
        deadline = cyc + limit;
        tick();
        i_start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_run(input int limit);
        for (int i = 0; i < limit; i++) begin
            tick();
            if (wq.size() == 0 && dq.size() == 0) break;
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_stretch_en = 1'b0;
        i_total = '0; i_rad_min = '0; i_rad_range = '0;
        i_lut_we = 1'b0; i_lut_addr = '0; i_lut_wdata = '0;
        repeat (3) @(posedge i_clk);
        #1;
        rst_n = 1'b1;
        pq.push_back('{full: 1'b1, busy: 1'b0, done: 1'b0, wen: 1'b0, addr: 18'd0,
                       wdata: 16'd0, mn: 8'hFF, mx: 8'h00});
        tick();

        // Identity LUT, no stretch
        load_px(0, 16'd0); load_px(1, 16'd64); load_px(2, 16'd128); load_px(3, 16'd255);
        push_wr(0, 16'd0); push_wr(1, 16'd64); push_wr(2, 16'd128); push_wr(3, 16'd255);
        push_done(17, 8'd0, 8'd255, 16);
        start_run(18'd4, 1'b0, 16'd0, 16'd256, 40);
        wait_run(60);

        // Stretch pass
        load_px(0, 16'd100); load_px(1, 16'd150);
        push_wr(0, 16'd0); push_wr(1, 16'd128); push_wr(0, 16'd0); push_wr(1, 16'd255);
        push_done(17, 8'd0, 8'd128, 16);
        start_run(18'd2, 1'b1, 16'd100, 16'd100, 40);
        wait_run(60);

        // Zero range, equal pixels, stretch on
        for (int k = 0; k < 3; k++) load_px(4'(k), 16'd500);
        for (int p = 0; p < 2; p++) for (int k = 0; k < 3; k++) push_wr(18'(k), 16'd0);
        push_done(25, 8'd0, 8'd0, 24);
        start_run(18'd3, 1'b1, 16'd0, 16'd0, 50);
        wait_run(70);

        // Below window, far above window, just inside top
        load_px(0, 16'd50); load_px(1, 16'd1000); load_px(2, 16'd199);
        push_wr(0, 16'd0); push_wr(1, 16'd255); push_wr(2, 16'd253);
        push_done(13, 8'd0, 8'd255, 12);
        start_run(18'd3, 1'b0, 16'd100, 16'd100, 40);
        wait_run(60);

        // Abort during pass-2 read of pixel 0
        load_px(0, 16'd100); load_px(1, 16'd150);
        push_wr(0, 16'd0); push_wr(1, 16'd128);
        start_run(18'd2, 1'b1, 16'd100, 16'd100, 40);
        repeat (9) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        repeat (10) tick();
        pq.push_back('{full: 1'b0, busy: 1'b0, done: 1'b0, wen: 1'b0, addr: 18'd0,
                       wdata: 16'd0, mn: 8'd0, mx: 8'd128});
        tick();

        // Zero pixels
        push_done(1, 8'hFF, 8'h00, 0);
        start_run(18'd0, 1'b1, 16'd0, 16'd256, 20);
        wait_run(30);

        // Start while busy is ignored
        load_px(0, 16'd0); load_px(1, 16'd64); load_px(2, 16'd128); load_px(3, 16'd255);
        push_wr(0, 16'd0); push_wr(1, 16'd64); push_wr(2, 16'd128); push_wr(3, 16'd255);
        push_done(17, 8'd0, 8'd255, 16);
        start_run(18'd4, 1'b0, 16'd0, 16'd256, 40);
        repeat (4) tick();
        i_start = 1'b1; i_total = 18'd2; i_stretch_en = 1'b1;
        tick();
        i_start = 1'b0;
        wait_run(60);

        // LUT write in the same cycle as start
        load_px(0, 16'd128);
        push_wr(0, 16'h0033);
        push_done(5, 8'h33, 8'h33, 4);
        i_lut_we = 1'b1; i_lut_addr = 8'd128; i_lut_wdata = 8'h33;
        start_run(18'd1, 1'b0, 16'd0, 16'd256, 20);
        i_lut_we = 1'b0;
        wait_run(30);

        // Inverted LUT, with a write attempt while busy
        for (int k = 0; k < 256; k++) lut_write(8'(k), 8'(255 - k));
        load_px(0, 16'd0); load_px(1, 16'd64); load_px(2, 16'd128); load_px(3, 16'd255);
        push_wr(0, 16'd255); push_wr(1, 16'd191); push_wr(2, 16'd127); push_wr(3, 16'd0);
        push_done(17, 8'd0, 8'd255, 16);
        start_run(18'd4, 1'b0, 16'd0, 16'd256, 40);
        i_lut_we = 1'b1; i_lut_addr = 8'd64; i_lut_wdata = 8'h5A;
        tick();
        i_lut_we = 1'b0;
        wait_run(60);

        // LUT[64] must still hold the inverted value
        load_px(0, 16'd64);
        push_wr(0, 16'd191);
        push_done(5, 8'd191, 8'd191, 4);
        start_run(18'd1, 1'b0, 16'd0, 16'd256, 20);
        wait_run(30);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
